// File: rtl/burst_ram_pkg.sv
// rtl/burst_ram_pkg.sv - shared states, command codes and sizing helpers for burst_ram_responder
package burst_ram_pkg;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_RD_BURST = 3'd3,
        ST_WR_BURST = 3'd4,
        ST_REFRESH  = 3'd5
    } state_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam int REFRESH_PERIOD = 256;
    localparam int REFRESH_LEN    = 4;

    function automatic int beat_bits(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/burst_ram_array.sv
// rtl/burst_ram_array.sv - byte-write-enabled synchronous RAM, one write port and one registered read port
module burst_ram_array #(
    parameter int AW = 8,
    parameter int DW = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic [DW/8-1:0]   wr_be,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DW-1:0]     rd_data
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Output register only updates on a read, so the last beat is held between bursts.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/burst_ram_responder.sv
// rtl/burst_ram_responder.sv - BurstRAM command responder; optional refresh via BURST_RAM_REFRESH_EN
module burst_ram_responder
    import burst_ram_pkg::*;
#(
    parameter int RAM_DEPTH_BITWIDTH      = 8,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int RAM_BURST_DATA_COUNT    = 4,
    parameter int READ_LATENCY            = 3,
    parameter int INIT_CYCLES             = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 br_cmd,
    input  logic                                 br_cmd_en,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    output logic                                 br_rd_data_valid,
    output logic                                 br_busy
);
    localparam int AW      = RAM_DEPTH_BITWIDTH;
    localparam int DW      = RAM_BURST_DATA_BITWIDTH;
    localparam int BEAT_W  = beat_bits(RAM_BURST_DATA_COUNT);
    localparam int CNT_MAX = (INIT_CYCLES > READ_LATENCY) ?
                             ((INIT_CYCLES > REFRESH_LEN) ? INIT_CYCLES : REFRESH_LEN) :
                             ((READ_LATENCY > REFRESH_LEN) ? READ_LATENCY : REFRESH_LEN);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RD_LAST   = CNT_W'(READ_LATENCY - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(RAM_BURST_DATA_COUNT - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [BEAT_W-1:0]  beat;
    logic [BEAT_W-1:0]  next_beat;
    logic [AW-1:0]      addr;
    logic               refresh_due;
    logic               accept;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;

`ifdef BURST_RAM_REFRESH_EN
    localparam int                REF_W    = $clog2(REFRESH_PERIOD);
    localparam logic [CNT_W-1:0]  REF_LAST = CNT_W'(REFRESH_LEN - 1);

    logic [REF_W-1:0] ref_cnt;
    logic             ref_pending;

    // A refresh falling due mid-burst is remembered and taken on the next IDLE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else begin
            ref_cnt <= ref_cnt + REF_W'(1);
            if (state == ST_IDLE) begin
                ref_pending <= 1'b0;
            end else if (ref_cnt == REF_W'(REFRESH_PERIOD - 1)) begin
                ref_pending <= 1'b1;
            end
        end
    end

    assign refresh_due = ref_pending || (ref_cnt == REF_W'(REFRESH_PERIOD - 1));
`else
    assign refresh_due = 1'b0;
`endif

    assign accept    = (state == ST_IDLE) && br_cmd_en && !refresh_due;
    assign next_beat = beat + BEAT_W'(1);

    assign wr_en   = !rst && ((accept && br_cmd == CMD_WRITE) || state == ST_WR_BURST);
    assign wr_addr = (state == ST_WR_BURST) ? addr + AW'(beat) : br_addr;
    // Beat 0 is fetched on the last wait cycle, so data and valid register together.
    assign rd_en   = !rst && ((state == ST_RD_WAIT && cnt == RD_LAST) ||
                              (state == ST_RD_BURST && beat != BEAT_LAST));
    assign rd_addr = (state == ST_RD_BURST) ? addr + AW'(next_beat) : addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_INIT;
            cnt              <= '0;
            beat             <= '0;
            addr             <= '0;
            br_busy          <= 1'b1;
            br_rd_data_valid <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (cnt == INIT_LAST) begin
                        state   <= ST_IDLE;
                        cnt     <= '0;
                        br_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (refresh_due) begin
                        state   <= ST_REFRESH;
                        cnt     <= '0;
                        br_busy <= 1'b1;
                    end else if (br_cmd_en) begin
                        addr    <= br_addr;
                        cnt     <= '0;
                        br_busy <= 1'b1;
                        if (br_cmd == CMD_WRITE) begin
                            state <= ST_WR_BURST;
                            beat  <= BEAT_W'(1);
                        end else begin
                            state <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt == RD_LAST) begin
                        state            <= ST_RD_BURST;
                        beat             <= '0;
                        br_rd_data_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RD_BURST: begin
                    if (beat == BEAT_LAST) begin
                        state            <= ST_IDLE;
                        br_rd_data_valid <= 1'b0;
                        br_busy          <= 1'b0;
                    end else begin
                        beat <= next_beat;
                    end
                end
                ST_WR_BURST: begin
                    if (beat == BEAT_LAST) begin
                        state   <= ST_IDLE;
                        br_busy <= 1'b0;
                    end else begin
                        beat <= next_beat;
                    end
                end
`ifdef BURST_RAM_REFRESH_EN
                ST_REFRESH: begin
                    if (cnt == REF_LAST) begin
                        state   <= ST_IDLE;
                        br_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    state            <= ST_INIT;
                    cnt              <= '0;
                    br_busy          <= 1'b1;
                    br_rd_data_valid <= 1'b0;
                end
            endcase
        end
    end

    burst_ram_array #(
        .AW (AW),
        .DW (DW)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (br_wr_data),
        .wr_be   (~br_data_mask),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (br_rd_data)
    );

endmodule

// File: tb/tb_burst_ram_responder.sv
// tb/tb_burst_ram_responder.sv - directed table-driven bench for burst_ram_responder
module tb_burst_ram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_cmd = 1'b0;
    logic        br_cmd_en = 1'b0;
    logic [7:0]  br_addr = '0;
    logic [63:0] br_wr_data = '0;
    logic [7:0]  br_data_mask = '0;
    logic [63:0] br_rd_data;
    logic        br_rd_data_valid;
    logic        br_busy;

    int checks = 0;
    int fails  = 0;

    typedef logic [3:0][63:0] burst_t;

    typedef struct {
        bit         do_wr;
        logic [7:0] wa;
        burst_t     wd;
        logic [7:0] m0;
        logic [7:0] ra;
        burst_t     ex;
    } vec_t;

    vec_t tbl[6];

    burst_ram_responder dut (
        .clk              (clk),
        .rst              (rst),
        .br_cmd           (br_cmd),
        .br_cmd_en        (br_cmd_en),
        .br_addr          (br_addr),
        .br_wr_data       (br_wr_data),
        .br_data_mask     (br_data_mask),
        .br_rd_data       (br_rd_data),
        .br_rd_data_valid (br_rd_data_valid),
        .br_busy          (br_busy)
    );

    always #5 clk = ~clk;

    function automatic burst_t mk(input logic [63:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (br_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", {63'd0, br_busy}, 64'd0);
    endtask

    task automatic count_busy(output int n, output bit saw_valid);
        n = 0;
        saw_valid = 1'b0;
        while (br_busy && n < 100) begin
            if (br_rd_data_valid) saw_valid = 1'b1;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input burst_t wd, input logic [7:0] m0);
        wait_idle();
        br_cmd = 1'b1;
        br_cmd_en = 1'b1;
        br_addr = a;
        br_wr_data = wd[0];
        br_data_mask = m0;
        @(negedge clk);
        br_cmd_en = 1'b0;
        br_data_mask = '0;
        check("wr_busy", {63'd0, br_busy}, 64'd1);
        for (int i = 1; i < 4; i++) begin
            br_wr_data = wd[i];
            @(negedge clk);
        end
        check("wr_done_busy", {63'd0, br_busy}, 64'd0);
    endtask

    task automatic do_read(input logic [7:0] a, input bit inject, output burst_t got);
        int n;
        wait_idle();
        br_cmd = 1'b0;
        br_cmd_en = 1'b1;
        br_addr = a;
        @(negedge clk);
        br_cmd_en = 1'b0;
        check("rd_busy", {63'd0, br_busy}, 64'd1);
        n = 0;
        while (!br_rd_data_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rd_latency", 64'(n), 64'd3);
        for (int i = 0; i < 4; i++) begin
            got[i] = br_rd_data;
            check("rd_valid", {63'd0, br_rd_data_valid}, 64'd1);
            if (inject && i == 1) begin
                br_cmd = 1'b1;
                br_cmd_en = 1'b1;
                br_addr = a;
                br_wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
            end
            @(negedge clk);
            br_cmd_en = 1'b0;
        end
        check("rd_end_valid", {63'd0, br_rd_data_valid}, 64'd0);
        check("rd_end_busy", {63'd0, br_busy}, 64'd0);
        check("rd_hold", br_rd_data, got[3]);
    endtask

    initial begin
        burst_t got;
        burst_t b10;
        int     n;
        bit     sv;

        b10 = mk(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        tbl[0] = '{1'b1, 8'h10, b10, 8'h00, 8'h10, b10};
        tbl[1] = '{1'b1, 8'h20, mk(64'd0, 64'd0, 64'd0, 64'd0), 8'h00, 8'h20,
                   mk(64'd0, 64'd0, 64'd0, 64'd0)};
        tbl[2] = '{1'b1, 8'h20, mk({64{1'b1}}, {64{1'b1}}, {64{1'b1}}, {64{1'b1}}), 8'h0F, 8'h20,
                   mk(64'hFFFF_FFFF_0000_0000, {64{1'b1}}, {64{1'b1}}, {64{1'b1}})};
        tbl[3] = '{1'b1, 8'h02,
                   mk(64'h0202_0202_0202_0202, 64'h0303_0303_0303_0303,
                      64'h0404_0404_0404_0404, 64'h0505_0505_0505_0505), 8'h00, 8'h02,
                   mk(64'h0202_0202_0202_0202, 64'h0303_0303_0303_0303,
                      64'h0404_0404_0404_0404, 64'h0505_0505_0505_0505)};
        tbl[4] = '{1'b1, 8'hFE,
                   mk(64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                      64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD), 8'h00, 8'hFE,
                   mk(64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                      64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD)};
        tbl[5] = '{1'b0, 8'h00, mk(64'd0, 64'd0, 64'd0, 64'd0), 8'h00, 8'h00,
                   mk(64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD,
                      64'h0202_0202_0202_0202, 64'h0303_0303_0303_0303)};

        // Power-up: busy for exactly 16 sampled cycles, no valid beats.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_rd_data", br_rd_data, 64'd0);
        count_busy(n, sv);
        check("init_busy_cycles", 64'(n), 64'd16);
        check("init_valid", {63'd0, sv}, 64'd0);

        for (int v = 0; v < 6; v++) begin
            if (tbl[v].do_wr) do_write(tbl[v].wa, tbl[v].wd, tbl[v].m0);
            do_read(tbl[v].ra, 1'b0, got);
            for (int i = 0; i < 4; i++) check($sformatf("vec%0d_beat%0d", v, i), got[i], tbl[v].ex[i]);
        end

        // Write command pulsed mid read burst must be ignored.
        do_read(8'h10, 1'b1, got);
        for (int i = 0; i < 4; i++) check($sformatf("inject_beat%0d", i), got[i], b10[i]);
        do_read(8'h10, 1'b0, got);
        for (int i = 0; i < 4; i++) check($sformatf("after_inject_beat%0d", i), got[i], b10[i]);

        // Reset on beat 2 of a read.
        wait_idle();
        br_cmd = 1'b0;
        br_cmd_en = 1'b1;
        br_addr = 8'h10;
        @(negedge clk);
        br_cmd_en = 1'b0;
        n = 0;
        while (!br_rd_data_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        check("mid_beat2", br_rd_data, 64'h3333_3333_3333_3333);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", {63'd0, br_rd_data_valid}, 64'd0);
        check("mid_rst_busy", {63'd0, br_busy}, 64'd1);
        rst = 1'b0;
        count_busy(n, sv);
        check("mid_rst_busy_cycles", 64'(n), 64'd16);
        check("mid_rst_init_valid", {63'd0, sv}, 64'd0);

        do_read(8'h20, 1'b0, got);
        check("post_rst_beat0", got[0], 64'hFFFF_FFFF_0000_0000);
        check("post_rst_beat3", got[3], {64{1'b1}});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
